// File: rtl/banner_pkg.sv
// Shared constants and FSM encoding for the banner bitmap row reader.
package banner_pkg;

  localparam int unsigned ROW_BITS_D    = 1440;
  localparam int unsigned ROW_FIRST_D   = 1;
  localparam int unsigned ROW_LAST_D    = 39;
  localparam int unsigned WINDOW_D      = 640;
  localparam int unsigned SCROLL_STEP_D = 4;

  // Column index and scroll offset share one width (0..ROW_BITS-1).
  localparam int unsigned COL_W   = 11;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned PIX_X_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/banner_bit_sel.sv
// Combinational ROW_BITS:1 pixel selector; column 0 is the row MSB.
module banner_bit_sel
  import banner_pkg::*;
#(
  parameter int unsigned ROW_BITS = ROW_BITS_D
) (
  input  logic [ROW_BITS-1:0] i_row,
  input  logic [COL_W-1:0]    i_col,
  output logic                o_bit_c
);

  localparam logic [ROW_BITS-1:0] MSB_ONE = {1'b1, {(ROW_BITS-1){1'b0}}};

  logic [ROW_BITS-1:0] w_shift;

  // Shifting the selected column up to the MSB keeps the index width-agnostic.
  assign w_shift = i_row << i_col;
  assign o_bit_c = |(w_shift & MSB_ONE);

endmodule

// File: rtl/banner_row_reader.sv
// Walks the banner ROM rows and streams a scrolled WINDOW-wide slice of each row as pixels.
module banner_row_reader
  import banner_pkg::*;
#(
  parameter int unsigned ROW_BITS    = ROW_BITS_D,
  parameter int unsigned ROW_FIRST   = ROW_FIRST_D,
  parameter int unsigned ROW_LAST    = ROW_LAST_D,
  parameter int unsigned WINDOW      = WINDOW_D,
  parameter int unsigned SCROLL_STEP = SCROLL_STEP_D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                scroll_en,
  output logic [ADDR_W-1:0]   adder,
  input  logic [ROW_BITS-1:0] data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_bit,
  output logic [PIX_X_W-1:0]  pix_x,
  output logic [ADDR_W-1:0]   pix_y,
  output logic                busy,
  output logic                frame_done
);

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(ROW_BITS - 1);
  localparam logic [ADDR_W-1:0]  ADDR_FIRST = ADDR_W'(ROW_FIRST);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(ROW_LAST);
  localparam logic [PIX_X_W-1:0] X_LAST     = PIX_X_W'(WINDOW - 1);
  localparam logic [COL_W:0]     OFF_STEP   = (COL_W+1)'(SCROLL_STEP);
  localparam logic [COL_W:0]     OFF_MOD    = (COL_W+1)'(ROW_BITS);

  state_t                r_state,       w_state_nxt;
  logic [ADDR_W-1:0]     r_adder,       w_adder_nxt;
  logic [ROW_BITS-1:0]   r_row_buf,     w_row_buf_nxt;
  logic [COL_W-1:0]      r_col,         w_col_nxt;
  logic [COL_W-1:0]      r_offset,      w_offset_nxt;
  logic                  r_pix_valid,   w_pix_valid_nxt;
  logic [PIX_X_W-1:0]    r_pix_x,       w_pix_x_nxt;
  logic                  r_pix_bit,     w_pix_bit_nxt;
  logic                  r_busy,        w_busy_nxt;
  logic                  r_frame_done,  w_frame_done_nxt;

  logic                  w_xfer;
  logic [COL_W:0]        w_off_sum;
  logic [COL_W-1:0]      w_off_wrap;

  assign w_xfer     = r_pix_valid & pix_ready;
  assign w_off_sum  = {1'b0, r_offset} + OFF_STEP;
  assign w_off_wrap = (w_off_sum >= OFF_MOD) ? COL_W'(w_off_sum - OFF_MOD) : COL_W'(w_off_sum);

  // Pixel is selected from the next-cycle row/column so pix_bit can be registered.
  banner_bit_sel #(
    .ROW_BITS (ROW_BITS)
  ) u_bit_sel (
    .i_row   (w_row_buf_nxt),
    .i_col   (w_col_nxt),
    .o_bit_c (w_pix_bit_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_adder      <= '0;
      r_row_buf    <= '0;
      r_col        <= '0;
      r_offset     <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= '0;
      r_pix_bit    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_adder      <= w_adder_nxt;
      r_row_buf    <= w_row_buf_nxt;
      r_col        <= w_col_nxt;
      r_offset     <= w_offset_nxt;
      r_pix_valid  <= w_pix_valid_nxt;
      r_pix_x      <= w_pix_x_nxt;
      r_pix_bit    <= w_pix_bit_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_adder_nxt     = r_adder;
    w_row_buf_nxt   = r_row_buf;
    w_col_nxt       = r_col;
    w_offset_nxt    = r_offset;
    w_pix_valid_nxt = r_pix_valid;
    w_pix_x_nxt     = r_pix_x;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_FETCH;
          w_adder_nxt = ADDR_FIRST;
        end
      end
      ST_FETCH: begin
        w_row_buf_nxt   = data;
        w_col_nxt       = r_offset;
        w_pix_x_nxt     = '0;
        w_pix_valid_nxt = 1'b1;
        w_state_nxt     = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_xfer) begin
          w_pix_x_nxt = r_pix_x + 1'b1;
          w_col_nxt   = (r_col == COL_LAST) ? '0 : r_col + 1'b1;
          // Last column of the window closes the row.
          if (r_pix_x == X_LAST) begin
            w_pix_valid_nxt = 1'b0;
            if (r_adder != ADDR_LAST) begin
              w_adder_nxt = r_adder + 1'b1;
              w_state_nxt = ST_FETCH;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (scroll_en) begin
          w_offset_nxt = w_off_wrap;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    w_frame_done_nxt = (w_state_nxt == ST_DONE);
  end

  assign adder      = r_adder;
  assign pix_y      = r_adder;
  assign pix_valid  = r_pix_valid;
  assign pix_bit    = r_pix_bit;
  assign pix_x      = r_pix_x;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_banner_row_reader.sv
// Scoreboard bench: full-size reader for mapping/timing/backpressure/reset, small reader for scroll wrap.
`timescale 1ns/1ps
module tb_banner_row_reader;
  import banner_pkg::*;

  localparam int unsigned RB    = 1440;
  localparam int unsigned SRB   = 24;
  localparam int unsigned SWIN  = 8;
  localparam int unsigned SSTEP = 4;

  typedef struct {
    logic b;
    int   x;
    int   y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, scroll_en, m_ready;
  logic [ADDR_W-1:0] m_adder, m_y;
  logic [RB-1:0] m_data;
  logic m_valid, m_bit, m_busy, m_done;
  logic [PIX_X_W-1:0] m_x;

  logic s_start, s_scroll, s_ready;
  logic [ADDR_W-1:0] s_adder, s_y;
  logic [SRB-1:0] s_data;
  logic s_valid, s_bit, s_busy, s_done;
  logic [PIX_X_W-1:0] s_x;

  logic [RB-1:0]  rom   [0:63];
  logic [SRB-1:0] rom_s [0:63];

  int   n_chk = 0;
  int   n_fail = 0;
  int   fd_m = 0;
  int   fd_s = 0;
  logic dir_m = 1'b0;
  exp_t q_m[$];
  exp_t q_s[$];
  logic obs_s [0:7];

  always #5 clk = ~clk;

  assign m_data = rom[m_adder];
  assign s_data = rom_s[s_adder];

  banner_row_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .scroll_en(scroll_en),
    .adder(m_adder), .data(m_data), .pix_valid(m_valid), .pix_ready(m_ready),
    .pix_bit(m_bit), .pix_x(m_x), .pix_y(m_y), .busy(m_busy), .frame_done(m_done)
  );

  banner_row_reader #(
    .ROW_BITS(SRB), .ROW_FIRST(1), .ROW_LAST(2), .WINDOW(SWIN), .SCROLL_STEP(SSTEP)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .scroll_en(s_scroll),
    .adder(s_adder), .data(s_data), .pix_valid(s_valid), .pix_ready(s_ready),
    .pix_bit(s_bit), .pix_x(s_x), .pix_y(s_y), .busy(s_busy), .frame_done(s_done)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endfunction

  // Expected pixel stream for one full-size frame at a given offset.
  function automatic void push_main(int off);
    exp_t e;
    logic [10:0] idx;
    for (int y = 1; y <= 39; y++) begin
      for (int x = 0; x < 640; x++) begin
        idx = 11'(RB - 1 - ((x + off) % RB));
        e.b = rom[6'(y)][idx];
        e.x = x;
        e.y = y;
        q_m.push_back(e);
      end
    end
  endfunction

  function automatic void push_small(int off);
    exp_t e;
    logic [4:0] idx;
    for (int y = 1; y <= 2; y++) begin
      for (int x = 0; x < int'(SWIN); x++) begin
        idx = 5'(SRB - 1 - ((x + off) % SRB));
        e.b = rom_s[6'(y)][idx];
        e.x = x;
        e.y = y;
        q_s.push_back(e);
      end
    end
  endfunction

  // Full-size monitor: scoreboard pop on transfer, stall stability, fixed-row spot checks.
  logic p_stall = 1'b0;
  logic p_bit;
  logic [PIX_X_W-1:0] p_x;
  logic [ADDR_W-1:0] p_y;
  exp_t em;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("stall_valid", 64'(m_valid), 64'(1));
        chk("stall_bit", 64'(m_bit), 64'(p_bit));
        chk("stall_x", 64'(m_x), 64'(p_x));
        chk("stall_y", 64'(m_y), 64'(p_y));
      end
      if (m_valid && m_ready) begin
        if (q_m.size() == 0) begin
          fail_now("unexpected_pixel");
        end else begin
          em = q_m.pop_front();
          chk("pix_bit", 64'(m_bit), 64'(em.b));
          chk("pix_x", 64'(m_x), 64'(em.x));
          chk("pix_y", 64'(m_y), 64'(em.y));
          chk("adder_eq_y", 64'(m_adder), 64'(em.y));
        end
        if (m_y == 6'd1 || m_y == 6'd39) chk("zero_row", 64'(m_bit), 64'(0));
        if (dir_m && m_y == 6'd2 && m_x <= 10'd12) chk("row2_nibble", 64'(m_bit), 64'(m_x == 10'd12));
      end
      p_stall = m_valid && !m_ready;
      p_bit   = m_bit;
      p_x     = m_x;
      p_y     = m_y;
      if (m_done) begin
        fd_m++;
        chk("done_queue_empty", 64'(q_m.size()), 64'(0));
      end
    end
  end

  exp_t es;
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid && s_ready) begin
        if (q_s.size() == 0) begin
          fail_now("unexpected_small_pixel");
        end else begin
          es = q_s.pop_front();
          chk("s_pix_bit", 64'(s_bit), 64'(es.b));
          chk("s_pix_x", 64'(s_x), 64'(es.x));
          chk("s_pix_y", 64'(s_y), 64'(es.y));
        end
        if (s_y == 6'd1 && s_x < 10'd8) obs_s[3'(s_x)] = s_bit;
      end
      if (s_done) fd_s++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_adder"}, 64'(m_adder), 64'(0));
    chk({tag, "_valid"}, 64'(m_valid), 64'(0));
    chk({tag, "_bit"}, 64'(m_bit), 64'(0));
    chk({tag, "_x"}, 64'(m_x), 64'(0));
    chk({tag, "_y"}, 64'(m_y), 64'(0));
    chk({tag, "_busy"}, 64'(m_busy), 64'(0));
    chk({tag, "_done"}, 64'(m_done), 64'(0));
  endtask

  task automatic run_small(int off);
    bit got;
    for (int i = 0; i < 8; i++) obs_s[i] = 1'b0;
    push_small(off);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      if (s_done) got = 1;
      else tick();
    end
    if (!got) fail_now("small_frame_timeout");
    tick();
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  exp_w;
    int          cyc;
    int          fd_before;
    bit          got;

    for (int r = 0; r < 64; r++) begin
      w = (32'(r) * 32'h9E3779B9) ^ 32'h5BD1E995;
      rom[r]   = {45{w}};
      rom_s[r] = 24'h0;
    end
    rom[1] = '0;
    rom[39] = '0;
    rom[2][1439:1424] = 16'h0008;
    rom_s[1] = 24'h80000A;
    rom_s[2] = 24'h5A5A5A;

    rst_n = 1'b0; start = 1'b0; scroll_en = 1'b0; m_ready = 1'b1;
    s_start = 1'b0; s_scroll = 1'b0; s_ready = 1'b1;
    repeat (3) tick();
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_no_valid", 64'(m_valid), 64'(0));
    chk("idle_not_busy", 64'(m_busy), 64'(0));

    // Scroll wrap on the narrow reader: five scrolling frames take offset to 20.
    s_scroll = 1'b1;
    for (int f = 0; f < 5; f++) run_small(f * int'(SSTEP));
    run_small(20);
    exp_w = 8'b1010_1000;
    for (int i = 0; i < 8; i++) chk("wrap_cols", 64'(obs_s[i]), 64'(exp_w[7-i]));
    s_scroll = 1'b0;
    run_small(0);
    exp_w = 8'b1000_0000;
    for (int i = 0; i < 8; i++) chk("wrapped_to_zero", 64'(obs_s[i]), 64'(exp_w[7-i]));
    chk("small_frames", 64'(fd_s), 64'(7));
    chk("small_queue_empty", 64'(q_s.size()), 64'(0));

    // Frame A: ready high, timing, stray start pulses in STREAM and DONE.
    dir_m = 1'b1;
    push_main(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_rise", 64'(m_busy), 64'(1));
    chk("fetch_adder", 64'(m_adder), 64'(1));
    chk("fetch_no_valid", 64'(m_valid), 64'(0));
    cyc = 0;
    for (int n = 1; n <= 30000; n++) begin
      if (m_done) begin
        cyc = n;
        break;
      end
      start = (n == 1000);
      tick();
    end
    chk("frame_cycles", 64'(cyc), 64'(25000));
    chk("done_busy", 64'(m_busy), 64'(1));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_one_cycle", 64'(m_done), 64'(0));
    for (int i = 0; i < 3; i++) begin
      chk("no_restart", 64'(m_busy), 64'(0));
      tick();
    end
    chk("frames_after_a", 64'(fd_m), 64'(1));
    dir_m = 1'b0;

    // Frame B: random backpressure, scroll enabled so the next frame uses offset 4.
    scroll_en = 1'b1;
    push_main(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int n = 0; n < 40000 && !got; n++) begin
      if (m_done) got = 1;
      else begin
        m_ready = ($urandom_range(0, 7) != 0);
        tick();
      end
    end
    if (!got) fail_now("backpressure_timeout");
    m_ready = 1'b1;
    tick();
    scroll_en = 1'b0;
    chk("frames_after_b", 64'(fd_m), 64'(2));

    // Frame C: offset 4, reset mid-row.
    push_main(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int n = 0; n < 20000 && !got; n++) begin
      if (m_adder == 6'd20 && m_x == 10'd300) got = 1;
      else tick();
    end
    if (!got) fail_now("reach_row20_timeout");
    fd_before = fd_m;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q_m.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_no_valid", 64'(m_valid), 64'(0));
    chk("post_rst_no_done", 64'(fd_m), 64'(fd_before));

    // Frame D: restart from row 1 with offset back at 0.
    dir_m = 1'b1;
    push_main(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_adder", 64'(m_adder), 64'(1));
    got = 0;
    for (int n = 0; n < 2000 && !got; n++) begin
      if (m_y == 6'd3) got = 1;
      else tick();
    end
    if (!got) fail_now("restart_rows_timeout");
    chk("restart_consumed", 64'(q_m.size()), 64'(37 * 640));
    rst_n = 1'b0;
    q_m.delete();
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
